// File: rtl/ram_p2_arb_pkg.sv
// Shared definitions for the ram_p2 two-requester arbiter.
// Holds requester ids and the 2-way round-robin pick function.
package ram_p2_arb_pkg;

    localparam logic RR_REQ0 = 1'b0;
    localparam logic RR_REQ1 = 1'b1;

    // With both requesting, the pointer names the winner.
    function automatic logic [1:0] rr_pick(
        input logic [1:0] req,
        input logic       ptr
    );
        logic [1:0] gnt;
        gnt = req;
        if (req == 2'b11) begin
            gnt = (ptr == RR_REQ1) ? 2'b10 : 2'b01;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/ram_p2.sv
// Simple dual-port RAM: one write port, one registered read port.
// A same-address read during a write returns the old word.
module ram_p2 #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[write_addr] <= data;
        end
        q <= mem[read_addr];
    end

endmodule

// File: rtl/ram_p2_arb_rr_arb2.sv
// Two-way round-robin arbiter with a 1-bit favoured-requester pointer.
// After any grant the pointer moves to the requester that lost.
module rr_arb2
    import ram_p2_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr;
    logic ptr_nxt;

    assign gnt = rr_pick(req, ptr);

    always_comb begin
        ptr_nxt = ptr;
        if (gnt[0]) begin
            ptr_nxt = RR_REQ1;
        end else if (gnt[1]) begin
            ptr_nxt = RR_REQ0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= RR_REQ0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/ram_p2_arb.sv
// Arbiter/sequencer giving two clients shared access to one ram_p2.
// Write and read ports are granted independently, round-robin each.
module ram_p2_arb
    import ram_p2_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int FWD        = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [1:0]            wreq;
    logic [1:0]            rreq;
    logic [1:0]            wgnt;
    logic [1:0]            rgnt;
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] q;
    logic                  byp_hit;
    logic                  rpend;
    logic                  rid;
    logic                  byp_sel;
    logic [DATA_WIDTH-1:0] byp_data;

    assign wreq = {req1 & we1, req0 & we0};
    assign rreq = {req1 & ~we1, req0 & ~we0};

    rr_arb2 u_warb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (wreq),
        .gnt   (wgnt)
    );

    rr_arb2 u_rarb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (rreq),
        .gnt   (rgnt)
    );

    assign gnt0  = wgnt[0] | rgnt[0];
    assign gnt1  = wgnt[1] | rgnt[1];
    assign wr_en = |wgnt;
    assign rd_en = |rgnt;
    assign waddr = wgnt[1] ? addr1 : addr0;
    assign wdata = wgnt[1] ? wdata1 : wdata0;
    assign raddr = rgnt[1] ? addr1 : addr0;

    // The RAM returns old data on a collision; forward the new word instead.
    assign byp_hit = (FWD != 0) && wr_en && rd_en && (waddr == raddr);

    ram_p2 #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk        (clk),
        .we         (wr_en),
        .write_addr (waddr),
        .read_addr  (raddr),
        .data       (wdata),
        .q          (q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpend    <= 1'b0;
            rid      <= RR_REQ0;
            byp_sel  <= 1'b0;
            byp_data <= '0;
        end else begin
            rpend   <= rd_en;
            byp_sel <= byp_hit;
            if (rd_en) begin
                rid <= rgnt[1];
            end
            if (byp_hit) begin
                byp_data <= wdata;
            end
        end
    end

    assign rvalid0 = rpend & (rid == RR_REQ0);
    assign rvalid1 = rpend & (rid == RR_REQ1);
    assign rdata   = byp_sel ? byp_data : q;

endmodule
